// File: rtl/tanh_pkg.sv
// Shared types and fixed-point constants for the piecewise-linear tanh datapath.
// Constants are returned as raw integers scaled by 2^frac_w.
package tanh_pkg;

  typedef enum logic [2:0] {
    SEG_LIN,
    SEG_1,
    SEG_2,
    SEG_3,
    SEG_SAT
  } seg_e;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Segment thresholds: 0.5, 1.0, 2.0, 3.0
  function automatic int unsigned thr_half(input int unsigned frac_w);
    return 32'd1 << (frac_w - 32'd1);
  endfunction

  function automatic int unsigned thr_one(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  function automatic int unsigned thr_two(input int unsigned frac_w);
    return 32'd2 << frac_w;
  endfunction

  function automatic int unsigned thr_three(input int unsigned frac_w);
    return 32'd3 << frac_w;
  endfunction

  // Segment offsets: 0.25, 0.625, 0.75, and the largest magnitude below 1.0
  function automatic int unsigned off_quarter(input int unsigned frac_w);
    return (32'd1 << frac_w) / 32'd4;
  endfunction

  function automatic int unsigned off_five_eighths(input int unsigned frac_w);
    return (32'd5 << frac_w) / 32'd8;
  endfunction

  function automatic int unsigned off_three_quarters(input int unsigned frac_w);
    return (32'd3 << frac_w) / 32'd4;
  endfunction

  function automatic int unsigned sat_mag(input int unsigned frac_w);
    return (32'd1 << frac_w) - 32'd1;
  endfunction

endpackage

// File: rtl/tanh_pwl_core.sv
// Combinational segment math: maps |x| and its segment to the tanh magnitude.
// Kept standalone so the sigmoid block can share it.
module tanh_pwl_core
  import tanh_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  seg_e              seg_i,
  output logic [DATA_W-1:0] m_o
);

  localparam logic [DATA_W-1:0] OffQuarter = DATA_W'(off_quarter(FRAC_W));
  localparam logic [DATA_W-1:0] OffFive8   = DATA_W'(off_five_eighths(FRAC_W));
  localparam logic [DATA_W-1:0] OffThree4  = DATA_W'(off_three_quarters(FRAC_W));
  localparam logic [DATA_W-1:0] SatMag     = DATA_W'(sat_mag(FRAC_W));

  always_comb begin
    m_o = '0;
    unique case (seg_i)
      SEG_LIN: m_o = a_i;
      SEG_1:   m_o = (a_i >> 1) + OffQuarter;
      SEG_2:   m_o = (a_i >> 3) + OffFive8;
      SEG_3:   m_o = (a_i >> 4) + OffThree4;
      SEG_SAT: m_o = SatMag;
      default: m_o = '0;
    endcase
  end

endmodule

// File: rtl/tanh_pwl_stream.sv
// Three-stage streaming tanh unit: sign/abs/segment, PWL magnitude, truncate/negate.
// All stages advance together on a single enable; also counts consumed saturated results.
module tanh_pwl_stream
  import tanh_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned APPROX_LSB = 1,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [ID_W-1:0]   in_id_i,
  input  logic              in_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ID_W-1:0]   out_id_o,
  output logic              out_sat_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  sat_cnt_o
);

  localparam logic [DATA_W-1:0] ThrHalf  = DATA_W'(thr_half(FRAC_W));
  localparam logic [DATA_W-1:0] ThrOne   = DATA_W'(thr_one(FRAC_W));
  localparam logic [DATA_W-1:0] ThrTwo   = DATA_W'(thr_two(FRAC_W));
  localparam logic [DATA_W-1:0] ThrThree = DATA_W'(thr_three(FRAC_W));
  localparam logic [DATA_W-1:0] KeepMask = {DATA_W{1'b1}} << APPROX_LSB;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic              s1_neg_q, s1_neg_d;
  logic [DATA_W-1:0] s1_abs_q, s1_abs_d;
  seg_e              s1_seg_q, s1_seg_d;
  logic              s1_mode_q, s1_mode_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s1_sat_q, s1_sat_d;

  // Stage 2 registers
  logic              s2_valid_q, s2_valid_d;
  logic              s2_neg_q, s2_neg_d;
  logic [DATA_W-1:0] s2_mag_q, s2_mag_d;
  logic              s2_mode_q, s2_mode_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic              s2_sat_q, s2_sat_d;

  // Output stage registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_sat_q, out_sat_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              en;
  logic              x_neg;
  logic [DATA_W-1:0] x_abs;
  seg_e              x_seg;
  logic [DATA_W-1:0] core_mag;
  logic [DATA_W-1:0] mag_trunc;

  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;

  // Unsigned abs: the most-negative input maps to 2^(DATA_W-1) without overflow.
  always_comb begin
    x_neg = in_data_i[DATA_W-1];
    x_abs = x_neg ? (~in_data_i + DATA_W'(1)) : in_data_i;
    if (x_abs < ThrHalf) begin
      x_seg = SEG_LIN;
    end else if (x_abs < ThrOne) begin
      x_seg = SEG_1;
    end else if (x_abs < ThrTwo) begin
      x_seg = SEG_2;
    end else if (x_abs < ThrThree) begin
      x_seg = SEG_3;
    end else begin
      x_seg = SEG_SAT;
    end
  end

  tanh_pwl_core #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_core (
    .a_i  (s1_abs_q),
    .seg_i(s1_seg_q),
    .m_o  (core_mag)
  );

  // Truncation happens on the magnitude so negative results stay symmetric.
  always_comb begin
    mag_trunc = (s2_mode_q == MODE_APPROX) ? (s2_mag_q & KeepMask) : s2_mag_q;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_neg_d    = s1_neg_q;
    s1_abs_d    = s1_abs_q;
    s1_seg_d    = s1_seg_q;
    s1_mode_d   = s1_mode_q;
    s1_id_d     = s1_id_q;
    s1_sat_d    = s1_sat_q;
    s2_valid_d  = s2_valid_q;
    s2_neg_d    = s2_neg_q;
    s2_mag_d    = s2_mag_q;
    s2_mode_d   = s2_mode_q;
    s2_id_d     = s2_id_q;
    s2_sat_d    = s2_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sat_d   = out_sat_q;
    if (en) begin
      s1_valid_d  = in_valid_i;
      s1_neg_d    = x_neg;
      s1_abs_d    = x_abs;
      s1_seg_d    = x_seg;
      s1_mode_d   = in_mode_i;
      s1_id_d     = in_id_i;
      s1_sat_d    = (x_abs >= ThrThree);
      s2_valid_d  = s1_valid_q;
      s2_neg_d    = s1_neg_q;
      s2_mag_d    = core_mag;
      s2_mode_d   = s1_mode_q;
      s2_id_d     = s1_id_q;
      s2_sat_d    = s1_sat_q;
      out_valid_d = s2_valid_q;
      out_data_d  = s2_neg_q ? (~mag_trunc + DATA_W'(1)) : mag_trunc;
      out_id_d    = s2_id_q;
      out_sat_d   = s2_sat_q;
    end
  end

  // Clear takes priority; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready_i && out_sat_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_neg_q    <= 1'b0;
      s1_abs_q    <= '0;
      s1_seg_q    <= SEG_LIN;
      s1_mode_q   <= MODE_EXACT;
      s1_id_q     <= '0;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_neg_q    <= 1'b0;
      s2_mag_q    <= '0;
      s2_mode_q   <= MODE_EXACT;
      s2_id_q     <= '0;
      s2_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_neg_q    <= s1_neg_d;
      s1_abs_q    <= s1_abs_d;
      s1_seg_q    <= s1_seg_d;
      s1_mode_q   <= s1_mode_d;
      s1_id_q     <= s1_id_d;
      s1_sat_q    <= s1_sat_d;
      s2_valid_q  <= s2_valid_d;
      s2_neg_q    <= s2_neg_d;
      s2_mag_q    <= s2_mag_d;
      s2_mode_q   <= s2_mode_d;
      s2_id_q     <= s2_id_d;
      s2_sat_q    <= s2_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sat_q   <= out_sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_sat_o   = out_sat_q;
  assign sat_cnt_o   = cnt_q;

endmodule

// File: doc/tanh_pwl_stream.md
Name: tanh_pwl_stream

Overview:
- Streaming, parametrised signed fixed-point tanh activation unit.
- Successor to the fixed 4-bit combinational tanh approximators, generalised in width, format and mode, with a per-transaction exact/approximate mode select.
- 3-stage pipeline with valid/ready handshake, transaction ID pass-through and a saturation statistics counter.
- Sits between the MAC array output and the next layer's input buffer.

Parameters:
- DATA_W, 8, input/output word width, two's complement.
- FRAC_W, 4, fractional bits in both input and output. Legal only if DATA_W-FRAC_W-1 >= 2, so the input can reach 3.0.
- APPROX_LSB, 1, output magnitude LSBs forced to 0 in approximate mode. Range 0..FRAC_W-1.
- ID_W, 4, width of the transaction tag.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  unit accepts input this cycle
- in_data_i  in  DATA_W  x, signed Q(DATA_W-FRAC_W).FRAC_W
- in_id_i  in  ID_W  tag, returned unchanged
- in_mode_i  in  1  0 = exact PWL, 1 = approximate (LSB-truncated)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  tanh(x), same format as input
- out_id_o  out  ID_W  tag of the result
- out_sat_o  out  1  |x| >= 3.0 for this result
- cnt_clr_i  in  1  synchronous clear of sat_cnt_o
- sat_cnt_o  out  CNT_W  saturated results accepted downstream

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all stage valids 0, out_valid_o 0, out_data_o 0, out_id_o 0, out_sat_o 0, sat_cnt_o 0. An assertion mid-stream discards all in-flight samples. Nothing is emitted for them after release.
- Handshake:
  - en = !out_valid_o || out_ready_i. in_ready_o = en (combinational, so 1 after reset).
  - All three stages advance together when en = 1.
  - Input is accepted when in_valid_i && in_ready_o. Output is consumed when out_valid_o && out_ready_i.
  - Latency is 3 cycles from accept to out_valid_o. Throughput is 1 sample/cycle while out_ready_i = 1.
  - Bubbles are not collapsed. Output data, ID and sat are held stable while out_valid_o && !out_ready_i.
- Stage 1:
  - s = sign(x). a = |x| as an unsigned DATA_W value; x = most-negative gives a = 2^(DATA_W-1), with no overflow.
  - Segment select uses thresholds 0.5, 1.0, 2.0, 3.0 (in units of 2^-FRAC_W).
  - Register s, a, segment, mode, id and sat = (a >= 3.0).
- Stage 2, magnitude m (shifts are floor; constants scaled by 2^FRAC_W):
  - a < 0.5: m = a
  - 0.5 <= a < 1.0: m = (a>>1) + 0.25
  - 1.0 <= a < 2.0: m = (a>>3) + 0.625
  - 2.0 <= a < 3.0: m = (a>>4) + 0.75
  - a >= 3.0: m = 1.0 - 2^-FRAC_W
  - m is never >= 1.0.
- Stage 3:
  - If mode = 1, clear the low APPROX_LSB bits of m.
  - out = s ? -m : m. Zero input gives zero output. Truncation is applied to the magnitude before negation.
- Counter:
  - On each output consume with out_sat_o = 1, sat_cnt_o increments, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr_i clears it; clear wins over a simultaneous increment.
  - cnt_clr_i does not affect the pipeline.

Decomposition:
- Package tanh_pkg holds:
  - segment enum (SEG_LIN, SEG_1, SEG_2, SEG_3, SEG_SAT)
  - mode constants MODE_EXACT / MODE_APPROX
  - functions returning threshold and offset constants for a given FRAC_W
- One sub-module, tanh_pwl_core: the combinational stage-2 segment math (a, segment to m). It is reused by the future sigmoid block.
- Top level holds the pipeline registers, the handshake and the counter.

Test Plan (defaults, Q4.4):
1. Exact mode, back-to-back, out_ready_i = 1: x = 0x04, 0x0C, 0x18, 0x28, 0x30 -> outputs 0x04, 0x0A, 0x0D, 0x0E, 0x0F on consecutive cycles, first result 3 cycles after accept. IDs 0..4 return in order.
2. Negatives and boundaries: x = 0xE8 -> 0xF3; x = 0x80 -> 0xF1 with out_sat_o = 1; x = 0x00 -> 0x00; x = 0x08 -> 0x08; x = 0x2F -> 0x0E.
3. Approximate mode: x = 0x18 -> 0x0C; x = 0xE8 -> 0xF4; x = 0x04 -> 0x04. Mode toggled every sample; each result uses its own mode.
4. Backpressure: out_ready_i held 0 for 5 cycles with 4 samples offered -> in_ready_o drops once out_valid_o = 1, out_data_o is held, no sample is lost or duplicated, and the order is preserved on release.
5. Counter: 3 saturating samples consumed -> sat_cnt_o = 3. cnt_clr_i coinciding with a saturated consume -> sat_cnt_o = 0. With CNT_W = 2 and 5 saturated samples -> sat_cnt_o = 3.
6. Reset mid-stream: rst_n low with 3 samples in flight -> all outputs 0 immediately. No output after release until a new accept; then latency is 3.
